// File: rtl/hazard_dest_tracker.sv
// Destination-register tracker for the 5-stage pipeline: carries rd/write-enable
// through ID/EX, EX/MEM and MEM/WB and flags RAW hazards against the decoding instruction.
module hazard_dest_tracker #(
  parameter int unsigned REG_W     = 3,
  parameter int unsigned WB_BYPASS = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_rd_write,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             flush,
  input  logic             cnt_clr,
  output logic             stall,
  output logic [REG_W-1:0] rd_idex,
  output logic [REG_W-1:0] rd_exmem,
  output logic [REG_W-1:0] rd_memwb,
  output logic             wr_idex,
  output logic             wr_exmem,
  output logic             wr_memwb,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
  localparam logic             CheckMemWb = (WB_BYPASS == 0);

  logic             hitRs;
  logic             hitRt;
  logic [REG_W-1:0] idexRdNext;
  logic             idexWrNext;

  // Source match against every in-flight producer; MEM/WB only when the regfile can't bypass
  always_comb begin
    hitRs = (wr_idex  && (rd_idex  == id_rs)) ||
            (wr_exmem && (rd_exmem == id_rs)) ||
            (CheckMemWb && wr_memwb && (rd_memwb == id_rs));
    hitRt = (wr_idex  && (rd_idex  == id_rt)) ||
            (wr_exmem && (rd_exmem == id_rt)) ||
            (CheckMemWb && wr_memwb && (rd_memwb == id_rt));
  end

  assign stall = id_valid & ~flush & ((id_rs_used & hitRs) | (id_rt_used & hitRt));

  // ID/EX load: flushed, stalled or empty decode all become a bubble
  always_comb begin
    idexRdNext = '0;
    idexWrNext = 1'b0;
    if (!flush && !stall && id_valid) begin
      idexRdNext = id_rd;
      idexWrNext = id_rd_write;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_idex  <= '0;
      rd_exmem <= '0;
      rd_memwb <= '0;
      wr_idex  <= 1'b0;
      wr_exmem <= 1'b0;
      wr_memwb <= 1'b0;
    end else begin
      rd_memwb <= rd_exmem;
      wr_memwb <= wr_exmem;
      rd_exmem <= rd_idex;
      wr_exmem <= wr_idex;
      rd_idex  <= idexRdNext;
      wr_idex  <= idexWrNext;
    end
  end

  // Saturating stall-cycle counter, clear wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != CntMax)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_dest_tracker.sv
// Self-checking bench for hazard_dest_tracker: table of directed vectors plus
// hand sequences for stall length, mid-run reset and counter saturation.
module tb_hazard_dest_tracker;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [2:0] id_rd;
  logic       id_rd_write;
  logic [2:0] id_rs;
  logic [2:0] id_rt;
  logic       id_rs_used;
  logic       id_rt_used;
  logic       flush;
  logic       cnt_clr;

  logic        stallA, stallB, stallC;
  logic [2:0]  rdIA, rdEA, rdMA, rdIB, rdEB, rdMB, rdIC, rdEC, rdMC;
  logic        wrIA, wrEA, wrMA, wrIB, wrEB, wrMB, wrIC, wrEC, wrMC;
  logic [15:0] cntA, cntB;
  logic [3:0]  cntC;

  int passCnt = 0;
  int totalCnt = 0;

  hazard_dest_tracker #(.REG_W(3), .WB_BYPASS(1), .CNT_W(16)) dutA (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rd(id_rd), .id_rd_write(id_rd_write),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .flush(flush), .cnt_clr(cnt_clr), .stall(stallA),
    .rd_idex(rdIA), .rd_exmem(rdEA), .rd_memwb(rdMA),
    .wr_idex(wrIA), .wr_exmem(wrEA), .wr_memwb(wrMA), .stall_cnt(cntA));

  hazard_dest_tracker #(.REG_W(3), .WB_BYPASS(0), .CNT_W(16)) dutB (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rd(id_rd), .id_rd_write(id_rd_write),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .flush(flush), .cnt_clr(cnt_clr), .stall(stallB),
    .rd_idex(rdIB), .rd_exmem(rdEB), .rd_memwb(rdMB),
    .wr_idex(wrIB), .wr_exmem(wrEB), .wr_memwb(wrMB), .stall_cnt(cntB));

  hazard_dest_tracker #(.REG_W(3), .WB_BYPASS(1), .CNT_W(4)) dutC (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rd(id_rd), .id_rd_write(id_rd_write),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .flush(flush), .cnt_clr(cnt_clr), .stall(stallC),
    .rd_idex(rdIC), .rd_exmem(rdEC), .rd_memwb(rdMC),
    .wr_idex(wrIC), .wr_exmem(wrEC), .wr_memwb(wrMC), .stall_cnt(cntC));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [2:0] rd;
    logic       rdWrite;
    logic [2:0] rs;
    logic [2:0] rt;
    logic       rsUsed;
    logic       rtUsed;
    logic       fl;
    logic       clr;
    logic       eStall;
    logic [2:0] eRdI;
    logic       eWrI;
    logic [2:0] eRdE;
    logic       eWrE;
    logic [2:0] eRdM;
    logic       eWrM;
    logic [15:0] eCnt;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic drive(input logic v, input logic [2:0] rd, input logic w,
                       input logic [2:0] rs, input logic [2:0] rt,
                       input logic ru, input logic tu, input logic fl, input logic clr);
    id_valid = v; id_rd = rd; id_rd_write = w; id_rs = rs; id_rt = rt;
    id_rs_used = ru; id_rt_used = tu; flush = fl; cnt_clr = clr;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int nStall;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

    //            v  rd w  rs rt ru tu fl clr stl  I:rd w  E:rd w  M:rd w  cnt
    vecs[0]  = '{1, 3, 1, 0, 0, 0, 0, 0, 0, 0,   3, 1,   0, 0,   0, 0,   0};
    vecs[1]  = '{1, 4, 1, 3, 0, 1, 0, 0, 0, 1,   0, 0,   3, 1,   0, 0,   1};
    vecs[2]  = '{1, 4, 1, 3, 0, 1, 0, 0, 0, 1,   0, 0,   0, 0,   3, 1,   2};
    vecs[3]  = '{1, 4, 1, 3, 0, 1, 0, 0, 0, 0,   4, 1,   0, 0,   0, 0,   2};
    vecs[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0,   4, 1,   0, 0,   2};
    vecs[5]  = '{1, 5, 0, 0, 0, 0, 0, 0, 0, 0,   5, 0,   0, 0,   4, 1,   2};
    vecs[6]  = '{1, 6, 1, 5, 5, 1, 0, 0, 0, 0,   6, 1,   5, 0,   0, 0,   2};
    vecs[7]  = '{1, 7, 1, 0, 6, 0, 0, 0, 0, 0,   7, 1,   6, 1,   5, 0,   2};
    vecs[8]  = '{1, 2, 1, 0, 0, 0, 0, 0, 0, 0,   2, 1,   7, 1,   6, 1,   2};
    vecs[9]  = '{1, 1, 1, 2, 0, 1, 0, 1, 0, 0,   0, 0,   2, 1,   7, 1,   2};
    vecs[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0,   0, 0,   2, 1,   2};
    vecs[11] = '{1, 0, 1, 0, 0, 0, 0, 0, 0, 0,   0, 1,   0, 0,   0, 0,   2};
    vecs[12] = '{1, 3, 1, 0, 0, 0, 1, 0, 1, 1,   0, 0,   0, 1,   0, 0,   0};

    #12;
    check("reset_wr_idex", 32'(wrIA), 32'd0);
    check("reset_cnt", 32'(cntA), 32'd0);
    check("reset_stall", 32'(stallA), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table on the bypass instance
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(vecs[i].valid, vecs[i].rd, vecs[i].rdWrite, vecs[i].rs, vecs[i].rt,
            vecs[i].rsUsed, vecs[i].rtUsed, vecs[i].fl, vecs[i].clr);
      #1;
      check($sformatf("v%0d_stall", i), 32'(stallA), 32'(vecs[i].eStall));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_rd_idex", i),  32'(rdIA), 32'(vecs[i].eRdI));
      check($sformatf("v%0d_wr_idex", i),  32'(wrIA), 32'(vecs[i].eWrI));
      check($sformatf("v%0d_rd_exmem", i), 32'(rdEA), 32'(vecs[i].eRdE));
      check($sformatf("v%0d_wr_exmem", i), 32'(wrEA), 32'(vecs[i].eWrE));
      check($sformatf("v%0d_rd_memwb", i), 32'(rdMA), 32'(vecs[i].eRdM));
      check($sformatf("v%0d_wr_memwb", i), 32'(wrMA), 32'(vecs[i].eWrM));
      check($sformatf("v%0d_cnt", i),      32'(cntA), 32'(vecs[i].eCnt));
    end

    // Reset asserted with entries in flight clears everything before any edge
    @(negedge clk);
    drive(1, 6, 1, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    check("midrst_pre_wr_idex", 32'(wrIA), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_wr_idex", 32'(wrIA), 32'd0);
    check("midrst_wr_exmem", 32'(wrEA), 32'd0);
    check("midrst_wr_memwb", 32'(wrMA), 32'd0);
    check("midrst_rd_idex", 32'(rdIA), 32'd0);
    check("midrst_cnt", 32'(cntA), 32'd0);
    check("midrst_stall", 32'(stallA), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back RAW on the non-bypass instance: 3 stall cycles
    doReset();
    drive(1, 3, 1, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    drive(1, 4, 1, 3, 0, 1, 0, 0, 0);
    nStall = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (!stallB) break;
      nStall++;
      @(posedge clk);
      #1;
      check($sformatf("nobyp_bubble%0d", i), 32'(wrIB), 32'd0);
      @(negedge clk);
    end
    check("nobyp_stall_cycles", 32'(nStall), 32'd3);
    @(posedge clk);
    #1;
    check("nobyp_rd_idex", 32'(rdIB), 32'd4);
    check("nobyp_wr_idex", 32'(wrIB), 32'd1);
    check("nobyp_cnt", 32'(cntB), 32'd3);

    // Saturation on the 4-bit counter, then clear while stalling
    doReset();
    drive(1, 1, 1, 1, 0, 1, 0, 0, 0);
    repeat (30) @(posedge clk);
    #1;
    check("sat_cnt", 32'(cntC), 32'd15);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      if (stallC) break;
    end
    check("clr_stall_active", 32'(stallC), 32'd1);
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    check("clr_cnt", 32'(cntC), 32'd0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
